// File: rtl/noc_dev_tx.sv
// noc_dev_tx: serializes one parallel request per handshake into a framed NoC byte stream.
// Define NOC_DEV_TX_CHECKSUM_EN to append an XOR checksum byte to every packet.
module noc_dev_tx #(
    parameter logic [3:0] DEV_ID    = 4'h0,
    parameter logic [7:0] IDLE_DATA = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_dest,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_dlen,
    input  logic [63:0] req_data,
    input  logic        noc_stall,
    output logic        noc_from_dev_ctl,
    output logic [7:0]  noc_from_dev_data,
    output logic        busy,
    output logic        pkt_done
);

    // state | meaning (state names the byte currently on the link)
    // IDLE  | no packet, link shows IDLE_DATA
    // HDR   | header byte B0 (ctl=1)
    // ROUTE | B1 {dest, DEV_ID}
    // ADDR  | address bytes, LSB first
    // DATA  | payload bytes, LSB first
    // CSUM  | checksum byte (only with NOC_DEV_TX_CHECKSUM_EN)
`ifdef NOC_DEV_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, ROUTE, ADDR, DATA, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, ROUTE, ADDR, DATA} state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [3:0]  dest_q;
    logic [31:0] addr_q;
    logic [1:0]  dlen_q;
    logic [63:0] data_q;
    logic [2:0]  cnt_q, cnt_d;
    logic        ctl_q, ctl_d;
    logic [7:0]  byte_q, byte_d;
    logic [1:0]  addr_idx;
    logic [2:0]  data_idx;
    logic [2:0]  data_last;
    logic        has_data, consume, addr_end, data_end, last_byte, accept, to_tail;
`ifdef NOC_DEV_TX_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign has_data = (op_q == 3'd1) || (op_q == 3'd2);
    assign consume  = !noc_stall && (state_q != IDLE);
    assign addr_idx = cnt_q[1:0] + 2'd1;
    assign data_idx = cnt_q + 3'd1;
    assign addr_end = (cnt_q[1:0] == 2'd3);
    assign data_end = (cnt_q == data_last);

    always_comb begin
        data_last = 3'd0;
        case (dlen_q)
            2'd0: data_last = 3'd0;
            2'd1: data_last = 3'd1;
            2'd2: data_last = 3'd3;
            2'd3: data_last = 3'd7;
            default: data_last = 3'd0;
        endcase
    end

`ifdef NOC_DEV_TX_CHECKSUM_EN
    assign last_byte = consume && (state_q == CSUM);
`else
    assign last_byte = consume && (((state_q == ADDR) && addr_end && !has_data) ||
                                   ((state_q == DATA) && data_end));
`endif

    assign req_ready = (state_q == IDLE) || last_byte;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        byte_d  = byte_q;
        to_tail = 1'b0;
`ifdef NOC_DEV_TX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (consume) begin
            case (state_q)
                HDR: begin
                    state_d = ROUTE;
                    ctl_d   = 1'b0;
                    byte_d  = {dest_q, DEV_ID};
                end
                ROUTE: begin
                    state_d = ADDR;
                    cnt_d   = 3'd0;
                    byte_d  = addr_q[7:0];
                end
                ADDR: begin
                    if (!addr_end) begin
                        cnt_d  = cnt_q + 3'd1;
                        byte_d = addr_q[{addr_idx, 3'b000} +: 8];
                    end else if (has_data) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                        byte_d  = data_q[7:0];
                    end else begin
                        to_tail = 1'b1;
                    end
                end
                DATA: begin
                    if (!data_end) begin
                        cnt_d  = data_idx;
                        byte_d = data_q[{data_idx, 3'b000} +: 8];
                    end else begin
                        to_tail = 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef NOC_DEV_TX_CHECKSUM_EN
        // csum_q already covers the byte on the link, so it is the finished checksum here
        if (to_tail) begin
            state_d = CSUM;
            byte_d  = csum_q;
        end else if (consume && !last_byte) begin
            csum_d = csum_q ^ byte_d;
        end
`endif
        if (last_byte) begin
            state_d = IDLE;
            ctl_d   = 1'b0;
            byte_d  = IDLE_DATA;
        end
        if (accept) begin
            state_d = HDR;
            cnt_d   = 3'd0;
            ctl_d   = 1'b1;
            byte_d  = {req_op, 2'b00, 1'b0, req_dlen};
`ifdef NOC_DEV_TX_CHECKSUM_EN
            csum_d  = {req_op, 2'b00, 1'b0, req_dlen};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ctl_q   <= 1'b0;
            byte_q  <= IDLE_DATA;
            op_q    <= 3'd0;
            dest_q  <= 4'd0;
            addr_q  <= 32'd0;
            dlen_q  <= 2'd0;
            data_q  <= 64'd0;
`ifdef NOC_DEV_TX_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            byte_q  <= byte_d;
`ifdef NOC_DEV_TX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
            if (accept) begin
                op_q   <= req_op;
                dest_q <= req_dest;
                addr_q <= req_addr;
                dlen_q <= req_dlen;
                data_q <= req_data;
            end
        end
    end

    assign noc_from_dev_ctl  = ctl_q;
    assign noc_from_dev_data = byte_q;
    assign busy              = (state_q != IDLE);
    assign pkt_done          = last_byte;

endmodule

// File: tb/tb_noc_dev_tx.sv
// Bench for noc_dev_tx: a byte-queue reference model predicts every link cycle.
// Honours NOC_DEV_TX_CHECKSUM_EN when defined on the command line.
module tb_noc_dev_tx;
    localparam logic [3:0] DEV_ID    = 4'h1;
    localparam logic [7:0] IDLE_DATA = 8'h00;
`ifdef NOC_DEV_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_dest;
    logic [31:0] req_addr;
    logic [1:0]  req_dlen;
    logic [63:0] req_data;
    logic        noc_stall;
    logic        noc_from_dev_ctl;
    logic [7:0]  noc_from_dev_data;
    logic        busy, pkt_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          busy_cycles;
    logic [8:0]  seen;
    logic [8:0]  exp_q[$];

    noc_dev_tx #(.DEV_ID(DEV_ID), .IDLE_DATA(IDLE_DATA)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_dest(req_dest), .req_addr(req_addr),
        .req_dlen(req_dlen), .req_data(req_data),
        .noc_stall(noc_stall),
        .noc_from_dev_ctl(noc_from_dev_ctl), .noc_from_dev_data(noc_from_dev_data),
        .busy(busy), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    // Whole packet as a byte list, built straight from the framing rules.
    function automatic void push_pkt(input logic [2:0] op, input logic [3:0] dest,
                                     input logic [31:0] addr, input logic [1:0] dlen,
                                     input logic [63:0] data);
        logic [7:0] b[$];
        logic [7:0] x;
        b.push_back(8'(op) * 8'd32 + 8'(dlen));
        b.push_back(8'(dest) * 8'd16 + 8'(DEV_ID));
        for (int i = 0; i < 4; i++) b.push_back(8'(addr >> (8 * i)));
        if (op == 3'd1 || op == 3'd2)
            for (int i = 0; i < (1 << dlen); i++) b.push_back(8'(data >> (8 * i)));
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
        if (CS == 1) b.push_back(x);
        foreach (b[i]) exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, b[i]});
    endfunction

    task automatic run_cycle(input bit v, input logic [2:0] op, input logic [3:0] dest,
                             input logic [31:0] addr, input logic [1:0] dlen,
                             input logic [63:0] data, input bit stall, output bit accepted);
        bit active, exp_last, exp_rdy;
        @(negedge clk);
        active = (exp_q.size() > 0);
        seen   = {noc_from_dev_ctl, noc_from_dev_data};
        n_checks += 2;
        if (active) begin
            busy_cycles++;
            if (seen !== exp_q[0])
                begin n_fail++; $display("FAIL link_byte: got %h expected %h", seen, exp_q[0]); end
            if (busy !== 1'b1)
                begin n_fail++; $display("FAIL busy_active: got %b expected 1", busy); end
        end else begin
            if (seen !== {1'b0, IDLE_DATA})
                begin n_fail++; $display("FAIL link_idle: got %h expected %h", seen, {1'b0, IDLE_DATA}); end
            if (busy !== 1'b0)
                begin n_fail++; $display("FAIL busy_idle: got %b expected 0", busy); end
        end
        req_valid = v;
        if (v) begin
            req_op = op; req_dest = dest; req_addr = addr; req_dlen = dlen; req_data = data;
        end else begin
            req_op = 3'($urandom); req_dest = 4'($urandom); req_addr = $urandom;
            req_dlen = 2'($urandom); req_data = {$urandom, $urandom};
        end
        noc_stall = stall;
        #1;
        exp_last = active && (exp_q.size() == 1) && !stall;
        exp_rdy  = !active || exp_last;
        n_checks += 2;
        if (req_ready !== exp_rdy)
            begin n_fail++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy); end
        if (pkt_done !== exp_last)
            begin n_fail++; $display("FAIL pkt_done: got %b expected %b", pkt_done, exp_last); end
        accepted = v && exp_rdy;
        @(posedge clk);
        if (active && !stall) exp_q.delete(0);
        if (accepted) push_pkt(op, dest, addr, dlen, data);
    endtask

    task automatic drain(input int stall_pct);
        bit acc;
        for (int c = 0; c < 400 && exp_q.size() > 0; c++)
            run_cycle(1'b0, 3'd0, 4'd0, 32'd0, 2'd0, 64'd0, $urandom_range(0, 99) < stall_pct, acc);
        n_checks++;
        if (exp_q.size() != 0)
            begin n_fail++; $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size()); end
        run_cycle(1'b0, 3'd0, 4'd0, 32'd0, 2'd0, 64'd0, 1'b0, acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks += 5;
        if (noc_from_dev_ctl !== 1'b0)
            begin n_fail++; $display("FAIL %s_ctl: got %b expected 0", tag, noc_from_dev_ctl); end
        if (noc_from_dev_data !== IDLE_DATA)
            begin n_fail++; $display("FAIL %s_data: got %h expected %h", tag, noc_from_dev_data, IDLE_DATA); end
        if (busy !== 1'b0)
            begin n_fail++; $display("FAIL %s_busy: got %b expected 0", tag, busy); end
        if (req_ready !== 1'b1)
            begin n_fail++; $display("FAIL %s_ready: got %b expected 1", tag, req_ready); end
        if (pkt_done !== 1'b0)
            begin n_fail++; $display("FAIL %s_done: got %b expected 0", tag, pkt_done); end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; noc_stall = 1'b0;
        req_op = 3'd0; req_dest = 4'd0; req_addr = 32'd0; req_dlen = 2'd0; req_data = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_read();
        bit acc;
        run_cycle(1'b1, 3'd0, 4'h3, 32'h11223344, 2'd0, 64'd0, 1'b0, acc);
        busy_cycles = 0;
        drain(0);
        n_checks++;
        if (busy_cycles != 6 + CS)
            begin n_fail++; $display("FAIL read_busy_len: got %0d expected %0d", busy_cycles, 6 + CS); end
    endtask

    task automatic test_write(input bit with_stall);
        bit acc;
        bit stall_pat[7] = '{0, 0, 0, 1, 1, 1, 0};
        run_cycle(1'b1, 3'd1, 4'h5, 32'h0, 2'd2, 64'h12345678DDCCBBAA, 1'b0, acc);
        busy_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            run_cycle(1'b0, 3'd0, 4'd0, 32'd0, 2'd0, 64'd0, with_stall && stall_pat[i], acc);
            if (i == 0) begin
                n_checks++;
                if (seen !== 9'h122)
                    begin n_fail++; $display("FAIL write_header: got %h expected 122", seen); end
            end
        end
        drain(0);
        n_checks++;
        if (busy_cycles != (with_stall ? 13 : 10) + CS)
            begin n_fail++; $display("FAIL write_busy_len: got %0d expected %0d", busy_cycles, (with_stall ? 13 : 10) + CS); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        run_cycle(1'b1, 3'd2, 4'h7, 32'hCAFEF00D, 2'd3, 64'h0123456789ABCDEF, 1'b0, acc);
        busy_cycles = 0;
        for (int c = 0; c < 40 && exp_q.size() > 1; c++)
            run_cycle(1'b0, 3'd0, 4'd0, 32'd0, 2'd0, 64'd0, 1'b0, acc);
        run_cycle(1'b1, 3'd2, 4'h9, 32'h87654321, 2'd3, 64'hFEDCBA9876543210, 1'b0, acc);
        drain(0);
        n_checks++;
        if (busy_cycles != 28 + 2 * CS)
            begin n_fail++; $display("FAIL b2b_busy_len: got %0d expected %0d", busy_cycles, 28 + 2 * CS); end
    endtask

    task automatic test_reset_mid_packet();
        bit acc;
        run_cycle(1'b1, 3'd1, 4'h2, 32'hA5A5_5A5A, 2'd1, 64'h7788, 1'b0, acc);
        repeat (3) run_cycle(1'b0, 3'd0, 4'd0, 32'd0, 2'd0, 64'd0, 1'b0, acc);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; noc_stall = 1'b0;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        check_reset_outputs("midrst");
        run_cycle(1'b1, 3'd0, 4'h4, 32'h0BADBEEF, 2'd0, 64'd0, 1'b0, acc);
        drain(0);
    endtask

    task automatic test_random();
        bit acc;
        int pk = 0;
        for (int c = 0; c < 3000 && pk < 40; c++) begin
            run_cycle($urandom_range(0, 2) != 0, 3'($urandom), 4'($urandom), $urandom,
                      2'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) == 0, acc);
            if (acc) pk++;
        end
        n_checks++;
        if (pk < 40)
            begin n_fail++; $display("FAIL random_accepts: got %0d expected 40", pk); end
        drain(25);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write(1'b0);
        test_write(1'b1);
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
